// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, drives the instruction-memory address and
// captures the returned instruction into the IF/ID pipeline register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic        halt_req,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        halted,
    output logic [31:0] fetch_count
);

    typedef enum logic {
        S_RUN,
        S_HALTED
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] instr_n, pc4_n, count_n;
    logic        valid_n;
    logic [31:0] pc_plus4;

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;
    assign halted    = (state == S_HALTED);

    // Next-state and next IF/ID contents, priority halt > redirect > stall/flush
    always_comb begin
        state_n = state;
        pc_n    = pc;
        instr_n = if_id_instr;
        pc4_n   = if_id_pc4;
        valid_n = if_id_valid;
        count_n = fetch_count;
        case (state)
            S_RUN: begin
                if (halt_req) begin
                    state_n = S_HALTED;
                    instr_n = NOP_INSTR;
                    pc4_n   = '0;
                    valid_n = 1'b0;
                end else if (redirect) begin
                    pc_n    = {redirect_target[31:2], 2'b00};
                    instr_n = NOP_INSTR;
                    pc4_n   = '0;
                    valid_n = 1'b0;
                end else if (stall && flush) begin
                    instr_n = NOP_INSTR;
                    pc4_n   = '0;
                    valid_n = 1'b0;
                end else if (stall) begin
                    // hold everything
                end else if (flush) begin
                    pc_n    = pc_plus4;
                    instr_n = NOP_INSTR;
                    pc4_n   = '0;
                    valid_n = 1'b0;
                end else begin
                    pc_n    = pc_plus4;
                    instr_n = imem_instr;
                    pc4_n   = pc_plus4;
                    valid_n = 1'b1;
                    count_n = fetch_count + 32'd1;
                end
            end
            S_HALTED: begin
                // frozen until reset; IF/ID already holds the bubble
            end
            default: state_n = S_RUN;
        endcase
    end

    // State, PC and IF/ID registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= S_RUN;
            pc          <= RESET_PC;
            if_id_instr <= NOP_INSTR;
            if_id_pc4   <= '0;
            if_id_valid <= 1'b0;
            fetch_count <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            if_id_instr <= instr_n;
            if_id_pc4   <= pc4_n;
            if_id_valid <= valid_n;
            fetch_count <= count_n;
        end
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Requester side of the instruction-memory interface: owns the program counter and drives the word-aligned fetch address into the combinational instruction memory.
- Captures the returned instruction into the IF/ID pipeline register.
- Handles stall, flush, branch/jump redirect and halt for the 5-stage MIPS pipeline.
- Sits between the instruction memory and the decode stage.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- NOP_INSTR, 32'h00000000, bubble instruction written to IF/ID on flush, redirect or halt.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous, active-high reset.
- imem_addr  output  32  fetch address to instruction memory; equals the PC register (combinational).
- imem_instr  input  32  instruction returned combinationally for imem_addr in the same cycle.
- stall  input  1  hazard stall: hold PC and IF/ID.
- flush  input  1  squash IF/ID contents (bubble).
- redirect  input  1  branch taken / jump, from the EX stage.
- redirect_target  input  32  new PC on redirect.
- halt_req  input  1  stop fetching; sticky until reset.
- if_id_instr  output  32  registered instruction to decode.
- if_id_pc4  output  32  registered PC+4 of that instruction.
- if_id_valid  output  1  1 = if_id_instr is a real fetched instruction.
- halted  output  1  1 in the HALTED state.
- fetch_count  output  32  number of valid instructions latched into IF/ID.

Behaviour:
- Reset (RST=1 at a clock edge; overrides all other inputs, including mid-stall and mid-halt):
  - pc=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc4=0, if_id_valid=0.
  - State=RUN, halted=0, fetch_count=0.
- imem_addr = pc. No memory wait states. The instruction is available in the same cycle, so fetch-to-IF/ID latency is 1 clock.
- RUN state, per-edge priority (highest first):
  1. halt_req=1: state=HALTED. pc is held. IF/ID is loaded with a bubble (NOP_INSTR, valid=0).
  2. redirect=1: pc={redirect_target[31:2],2'b00}. The low two bits are forced to zero and no exception is raised. IF/ID is loaded with a bubble. Redirect overrides stall and flush.
  3. stall=1 and flush=1: pc is held; IF/ID is loaded with a bubble.
  4. stall=1: pc and all IF/ID fields are held unchanged.
  5. flush=1: pc=pc+4; IF/ID is loaded with a bubble.
  6. Otherwise:
     - pc=pc+4.
     - if_id_instr=imem_instr, if_id_pc4=pc+4, if_id_valid=1.
     - fetch_count increments.
- HALTED state:
  - halted=1. pc is frozen. IF/ID holds the bubble.
  - stall, flush, redirect and halt_req are ignored.
  - The only exit is RST.
- Arithmetic: pc+4 is a modulo-2^32 add. 32'hFFFFFFFC wraps to 32'h00000000. fetch_count also wraps modulo 2^32.
- A bubble always sets if_id_pc4=0.
- fetch_count increments only on case 6.
- All outputs are registered except imem_addr.
- There are no combinational paths from inputs to outputs.

Test Plan:
- Reset then 4 free-running clocks, memory holding 8C220004, 00441820, AC230008, 10600002 at words 0..3:
  - imem_addr steps 0, 4, 8, C, 10.
  - Each cycle, IF/ID shows the instruction at the previous imem_addr, ending with if_id_instr=10600002 and if_id_pc4=0x10.
  - fetch_count=4.
- stall held 2 cycles while pc=8:
  - pc stays 8 and if_id_instr stays 00441820 for both cycles.
  - On release, the next edge loads AC230008 with if_id_pc4=0xC.
- redirect=1, redirect_target=0x17, asserted together with stall=1 at pc=0xC:
  - Next pc=0x14.
  - IF/ID is a bubble (instr=0, valid=0, pc4=0).
  - fetch_count unchanged.
- stall=1 and flush=1 at pc=0x8:
  - pc stays 0x8 and IF/ID is a bubble.
  - With flush alone at pc=0x8, pc becomes 0xC and IF/ID is a bubble.
- halt_req at pc=0x10, then redirect to 0x0 and then stall on later cycles:
  - halted=1 and pc stays 0x10 through all later inputs.
  - RST returns pc=0, halted=0, fetch_count=0.
- Redirect to 0xFFFFFFFC, then one free clock:
  - pc wraps to 0x00000000.
  - if_id_pc4=0x00000000 with if_id_valid=1.
